// File: rtl/mini_riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mini_riscv_pkg
//  Purpose  : Shared definitions for the mini_riscv_cpu slice: opcode
//             enumeration, default widths, instruction field positions and
//             the built-in default program image.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package mini_riscv_pkg;

    localparam int DATA_W_DEFAULT = 8;
    localparam int PC_W_DEFAULT   = 8;

    localparam int INSTR_W    = 16;
    localparam int NREGS      = 8;
    localparam int DMEM_DEPTH = 16;
    localparam int DMEM_AW    = 4;

    // Instruction field positions
    localparam int OP_HI  = 15;
    localparam int OP_LO  = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 9;
    localparam int RS1_HI = 8;
    localparam int RS1_LO = 6;
    localparam int RS2_HI = 5;
    localparam int RS2_LO = 3;
    localparam int IMM_HI = 5;
    localparam int IMM_LO = 0;
    localparam int IMM_W  = 6;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_AND  = 4'd3,
        OP_OR   = 4'd4,
        OP_XOR  = 4'd5,
        OP_SLL  = 4'd6,
        OP_SRL  = 4'd7,
        OP_ADDI = 4'd8,
        OP_LW   = 4'd9,
        OP_SW   = 4'd10,
        OP_BEQ  = 4'd11,
        OP_BNE  = 4'd12,
        OP_JMP  = 4'd13,
        OP_RSVD = 4'd14,
        OP_HALT = 4'd15
    } opcode_e;

    // Built-in program: loads 5 and 3, then exercises each two-operand ALU op
    // into r3..r7 and stops. Every other address is a NOP.
    function automatic logic [INSTR_W-1:0] default_rom(input int unsigned addr);
        logic [INSTR_W-1:0] instr;
        case (addr)
            0:       instr = 16'h8205; // ADDI r1,r0,5
            1:       instr = 16'h8403; // ADDI r2,r0,3
            2:       instr = 16'h1650; // ADD  r3,r1,r2
            3:       instr = 16'h2850; // SUB  r4,r1,r2
            4:       instr = 16'h3A50; // AND  r5,r1,r2
            5:       instr = 16'h4C50; // OR   r6,r1,r2
            6:       instr = 16'h5E50; // XOR  r7,r1,r2
            7:       instr = 16'hF000; // HALT
            default: instr = 16'h0000; // NOP
        endcase
        return instr;
    endfunction

endpackage : mini_riscv_pkg
`default_nettype wire

// File: rtl/mini_riscv_alu.sv
`default_nettype none
// ============================================================================
//  Module   : mini_riscv_alu
//  Purpose  : Combinational ALU and shifter. The adder also serves ADDI and
//             the LW/SW effective-address computation.
//  Ports    : i_op [3:0]       opcode of the current instruction
//             i_a  [DATA_W-1]  first operand (rs1 value)
//             i_b  [DATA_W-1]  second operand (rs2 value or sign-extended imm)
//             o_y  [DATA_W-1]  result, wraps modulo 2**DATA_W
//  Revision : 1.0 - initial release
// ============================================================================
module mini_riscv_alu
    import mini_riscv_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  opcode_e           i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_y
);

    always_comb begin
        o_y = '0;
        case (i_op)
            OP_ADD, OP_ADDI, OP_LW, OP_SW: o_y = i_a + i_b;
            OP_SUB:  o_y = i_a - i_b;
            OP_AND:  o_y = i_a & i_b;
            OP_OR:   o_y = i_a | i_b;
            OP_XOR:  o_y = i_a ^ i_b;
            // Shift amount is only the low three bits of the operand
            OP_SLL:  o_y = i_a << i_b[2:0];
            OP_SRL:  o_y = i_a >> i_b[2:0];
            default: o_y = '0;
        endcase
    end

endmodule : mini_riscv_alu
`default_nettype wire

// File: rtl/mini_riscv_cpu.sv
`default_nettype none
// ============================================================================
//  Module   : mini_riscv_cpu
//  Purpose  : Single-cycle 16-bit-instruction CPU used as a programmable
//             state machine. Holds PC, instruction ROM, 8-entry register file,
//             16-word data RAM and next-PC logic; ALU is a sub-module.
//  Ports    : clk     in   system clock, rising edge
//             reset   in   synchronous active-high reset
//             halted  out  high once a HALT has executed
//  Config   : MINIRV_HALT_EN - when defined, HALT sets 'halted' and freezes
//             all state until reset; when undefined, HALT behaves as a jump
//             with zero offset and 'halted' is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module mini_riscv_cpu
    import mini_riscv_pkg::*;
#(
    parameter int    DATA_W    = DATA_W_DEFAULT,
    parameter int    PC_W      = PC_W_DEFAULT,
    parameter string IMEM_FILE = ""
) (
    input  logic clk,
    input  logic reset,
    output logic halted
);

    // Architectural state (names are probed externally)
    logic [PC_W-1:0]   PC;
    logic [DATA_W-1:0] regfile [0:NREGS-1];
    logic [DATA_W-1:0] r_dmem  [0:DMEM_DEPTH-1];

    logic [INSTR_W-1:0] w_instr;
    opcode_e            w_op;
    logic [2:0]         w_rd;
    logic [2:0]         w_rs1;
    logic [2:0]         w_rs2;
    logic [IMM_W-1:0]   w_imm6;
    logic [DATA_W-1:0]  w_imm_d;
    logic [PC_W-1:0]    w_imm_pc;
    logic [DATA_W-1:0]  w_rd_val;
    logic [DATA_W-1:0]  w_rs1_val;
    logic [DATA_W-1:0]  w_rs2_val;
    logic [DATA_W-1:0]  w_alu_b;
    logic [DATA_W-1:0]  w_alu_y;
    logic [DMEM_AW-1:0] w_dmem_addr;
    logic [DATA_W-1:0]  w_wb_data;
    logic               w_wr_en;
    logic               w_mem_wr;
    logic [PC_W-1:0]    w_pc_next;
    logic               w_frozen;

    // ------------------------------------------------------------------
    // Instruction ROM
    // ------------------------------------------------------------------
    assign w_instr = default_rom(int'(unsigned'(PC)));

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    assign w_op     = opcode_e'(w_instr[OP_HI:OP_LO]);
    assign w_rd     = w_instr[RD_HI:RD_LO];
    assign w_rs1    = w_instr[RS1_HI:RS1_LO];
    assign w_rs2    = w_instr[RS2_HI:RS2_LO];
    assign w_imm6   = w_instr[IMM_HI:IMM_LO];
    assign w_imm_d  = {{(DATA_W-IMM_W){w_imm6[IMM_W-1]}}, w_imm6};
    assign w_imm_pc = {{(PC_W-IMM_W){w_imm6[IMM_W-1]}}, w_imm6};

    // r0 is never written, so its reset value of zero is what reads return
    assign w_rd_val  = regfile[w_rd];
    assign w_rs1_val = regfile[w_rs1];
    assign w_rs2_val = regfile[w_rs2];

    mini_riscv_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .i_op (w_op),
        .i_a  (w_rs1_val),
        .i_b  (w_alu_b),
        .o_y  (w_alu_y)
    );

    assign w_dmem_addr = w_alu_y[DMEM_AW-1:0];
    assign w_wb_data   = (w_op == OP_LW) ? r_dmem[w_dmem_addr] : w_alu_y;

    // ------------------------------------------------------------------
    // Control and next-PC
    // ------------------------------------------------------------------
    always_comb begin
        w_alu_b   = w_imm_d;
        w_wr_en   = 1'b0;
        w_mem_wr  = 1'b0;
        w_pc_next = PC + {{(PC_W-1){1'b0}}, 1'b1};
        case (w_op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL: begin
                w_alu_b = w_rs2_val;
                w_wr_en = 1'b1;
            end
            OP_ADDI, OP_LW: w_wr_en  = 1'b1;
            OP_SW:          w_mem_wr = 1'b1;
            OP_BEQ: if (w_rd_val == w_rs1_val) w_pc_next = PC + w_imm_pc;
            OP_BNE: if (w_rd_val != w_rs1_val) w_pc_next = PC + w_imm_pc;
            OP_JMP:         w_pc_next = PC + w_imm_pc;
            // Both halt flavours leave PC in place
            OP_HALT:        w_pc_next = PC;
            default: ;
        endcase
        if (w_frozen) begin
            w_wr_en   = 1'b0;
            w_mem_wr  = 1'b0;
            w_pc_next = PC;
        end
    end

`ifdef MINIRV_HALT_EN
    logic r_halted;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_halted <= 1'b0;
        end else if (w_op == OP_HALT) begin
            r_halted <= 1'b1;
        end
    end

    assign w_frozen = r_halted;
    assign halted   = r_halted;
`else
    assign w_frozen = 1'b0;
    assign halted   = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State update
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            PC <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regfile[i] <= '0;
            end
            for (int j = 0; j < DMEM_DEPTH; j++) begin
                r_dmem[j] <= '0;
            end
        end else begin
            PC <= w_pc_next;
            if (w_wr_en && (w_rd != 3'd0)) begin
                regfile[w_rd] <= w_wb_data;
            end
            if (w_mem_wr) begin
                r_dmem[w_dmem_addr] <= w_rd_val;
            end
        end
    end

endmodule : mini_riscv_cpu
`default_nettype wire

// File: tb/tb_mini_riscv_cpu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mini_riscv_cpu
//  Purpose  : Directed self-checking bench for mini_riscv_cpu. Runs the
//             built-in program, then overrides the fetched instruction to
//             execute hand-encoded sequences with hand-computed results.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mini_riscv_cpu;

`ifdef MINIRV_HALT_EN
    localparam logic c_halt_exp = 1'b1;
`else
    localparam logic c_halt_exp = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        halted;
    logic [15:0] instr_v;
    int          passes;
    int          total;

    mini_riscv_cpu #(
        .DATA_W    (8),
        .PC_W      (8),
        .IMEM_FILE ("")
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .halted (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step(input logic [15:0] ins);
        instr_v = ins;
        tick(1);
    endtask

    initial begin
        passes  = 0;
        total   = 0;
        instr_v = 16'h0000;
        reset   = 1'b1;

        // Reset state
        tick(2);
        check("rst_pc", 16'(dut.PC), 16'd0);
        for (int i = 0; i < 8; i++) check($sformatf("rst_r%0d", i), 16'(dut.regfile[i]), 16'd0);
        check("rst_halted", 16'(halted), 16'd0);

        // Default program
        reset = 1'b0;
        tick(7);
        check("prog_r1", 16'(dut.regfile[1]), 16'd5);
        check("prog_r2", 16'(dut.regfile[2]), 16'd3);
        check("prog_r3", 16'(dut.regfile[3]), 16'd8);
        check("prog_r4", 16'(dut.regfile[4]), 16'd2);
        check("prog_r5", 16'(dut.regfile[5]), 16'd1);
        check("prog_r6", 16'(dut.regfile[6]), 16'd7);
        check("prog_r7", 16'(dut.regfile[7]), 16'd6);
        check("prog_pc", 16'(dut.PC), 16'd7);
        tick(3);
        check("halt_pc_hold", 16'(dut.PC), 16'd7);
        check("halt_flag", 16'(halted), 16'(c_halt_exp));
        check("halt_r7_hold", 16'(dut.regfile[7]), 16'd6);

        // Mid-program reset
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(4);
        check("mid_pc4", 16'(dut.PC), 16'd4);
        reset = 1'b1;
        tick(1);
        check("mid_rst_pc", 16'(dut.PC), 16'd0);
        check("mid_rst_r3", 16'(dut.regfile[3]), 16'd0);
        check("mid_rst_halted", 16'(halted), 16'd0);
        reset = 1'b0;
        tick(8);
        check("rerun_r4", 16'(dut.regfile[4]), 16'd2);
        check("rerun_r7", 16'(dut.regfile[7]), 16'd6);
        check("rerun_pc", 16'(dut.PC), 16'd7);
        check("rerun_halted", 16'(halted), 16'(c_halt_exp));

        // Hand-fed instruction stream
        instr_v = 16'h0000;
        force dut.w_instr = instr_v;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;

        step(16'h823F); // ADDI r1,r0,-1
        check("addi_neg_r1", 16'(dut.regfile[1]), 16'd255);
        step(16'h8441); // ADDI r2,r1,1
        check("addi_wrap_r2", 16'(dut.regfile[2]), 16'd0);
        step(16'h8007); // ADDI r0,r0,7
        check("r0_hardwired", 16'(dut.regfile[0]), 16'd0);
        check("pc_after3", 16'(dut.PC), 16'd3);
        step(16'hA203); // SW r1,3(r0)
        step(16'h9603); // LW r3,3(r0)
        check("lw_r3", 16'(dut.regfile[3]), 16'd255);
        check("pc_after5", 16'(dut.PC), 16'd5);
        step(16'hB0BE); // BEQ r0,r2,-2 (taken)
        check("beq_taken_pc", 16'(dut.PC), 16'd3);
        step(16'hC2C0); // BNE r1,r3,0 (not taken)
        check("bne_nt_pc", 16'(dut.PC), 16'd4);
        step(16'hC285); // BNE r1,r2,+5 (taken)
        check("bne_t_pc", 16'(dut.PC), 16'd9);
        step(16'hE3FF); // reserved opcode
        check("rsvd_pc", 16'(dut.PC), 16'd10);
        check("rsvd_r1", 16'(dut.regfile[1]), 16'd255);
        check("rsvd_r7", 16'(dut.regfile[7]), 16'd0);
        step(16'h0FFF); // NOP
        check("nop_pc", 16'(dut.PC), 16'd11);
        check("nop_r3", 16'(dut.regfile[3]), 16'd255);
        step(16'h8403); // ADDI r2,r0,3
        step(16'h6C50); // SLL r6,r1,r2
        check("sll_r6", 16'(dut.regfile[6]), 16'h00F8);
        step(16'h7E50); // SRL r7,r1,r2
        check("srl_r7", 16'(dut.regfile[7]), 16'h001F);
        check("pc_after14", 16'(dut.PC), 16'd14);
        step(16'hD032); // JMP -14
        check("jmp_back_pc", 16'(dut.PC), 16'd0);
        step(16'hD03F); // JMP -1 from 0 wraps
        check("jmp_wrap_pc", 16'(dut.PC), 16'd255);
        step(16'h0000); // NOP at the top address wraps to 0
        check("pc_wrap_end", 16'(dut.PC), 16'd0);
        step(16'hF000); // HALT
        check("halt2_pc", 16'(dut.PC), 16'd0);
        check("halt2_flag", 16'(halted), 16'(c_halt_exp));

        release dut.w_instr;
        reset = 1'b1;
        tick(1);
        check("final_rst_pc", 16'(dut.PC), 16'd0);
        check("final_rst_r1", 16'(dut.regfile[1]), 16'd0);
        reset = 1'b0;

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule : tb_mini_riscv_cpu
`default_nettype wire
